instr_split_queue: RTL and testbench

- Parametrised instruction buffer and field splitter between fetch (IF) and decode (ID) in the pipelined MIPS CPU.
- Stores {pc, instr} pairs in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus a flush.
- Presents the head entry already split into op/rs/rt/rd/shamt/func/instr_index/imm, with extended immediates and the jump target.

---
 rtl/instr_split_queue.sv | 130 +++++++++++++
 tb/tb_instr_split_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_split_queue.sv
// Fetch-to-decode instruction FIFO.
// Presents the head entry split into MIPS fields.
module instr_split_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         in_pc,
  input  logic [31:0]             in_instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_W-1:0]         pc,
  output logic [31:0]             instr,
  output logic [5:0]              op,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [4:0]              shamt,
  output logic [5:0]              func,
  output logic [25:0]             instr_index,
  output logic [15:0]             imm,
  output logic [PC_W-1:0]         imm_sext,
  output logic [PC_W-1:0]         imm_zext,
  output logic [PC_W-1:0]         imm_lui,
  output logic [PC_W-1:0]         j_target,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PC_W-1:0] LO_MASK =
    PC_W'(32'h0FFF_FFFF);
  localparam logic [PC_W-1:0] HI_MASK = ~LO_MASK;

  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0] pc_mem_q  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [PC_W-1:0] pc4;

  assign in_ready  = (cnt_q != FULL);
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next pointer and occupancy; flush wins.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wp_q]  <= in_pc;
      ins_mem_q[wp_q] <= in_instr;
    end
  end

  // Head entry reads zero while empty.
  always_comb begin
    pc    = '0;
    instr = '0;
    if (out_valid) begin
      pc    = pc_mem_q[rp_q];
      instr = ins_mem_q[rp_q];
    end
  end

  assign op          = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign shamt       = instr[10:6];
  assign func        = instr[5:0];
  assign instr_index = instr[25:0];
  assign imm         = instr[15:0];

  assign imm_sext = {{(PC_W-16){imm[15]}}, imm};
  assign imm_zext = PC_W'(imm);
  assign imm_lui  = PC_W'({imm, 16'h0000});

  assign pc4      = pc + PC_W'(4);
  assign j_target = (pc4 & HI_MASK)
                  | PC_W'({instr_index, 2'b00});

endmodule

// File: tb/tb_instr_split_queue.sv
// Bench for instr_split_queue: scoreboard vs
// a queue-based reference of the split FIFO.
module tb_instr_split_queue;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [25:0] instr_index;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] imm_lui;
  logic [31:0] j_target;
  logic [1:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad   = 0;

  instr_split_queue #(
    .PC_W (PC_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc         (pc),
    .instr      (instr),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .func       (func),
    .instr_index(instr_index),
    .imm        (imm),
    .imm_sext   (imm_sext),
    .imm_zext   (imm_zext),
    .imm_lui    (imm_lui),
    .j_target   (j_target),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compare head against model, then
  // advance the model by the handshakes about
  // to be taken at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      int n;
      bit pu, po;
      logic [31:0] ep, ei, im;
      n = q.size();
      chk("count", 32'(count), 32'(n));
      chk("in_ready", 32'(in_ready),
          32'(n < DEPTH));
      chk("out_valid", 32'(out_valid),
          32'(n > 0));
      if (n > 0) begin
        ep = q[0].pc;
        ei = q[0].ins;
      end else begin
        ep = 0;
        ei = 0;
      end
      im = ei & 32'hFFFF;
      chk("pc", pc, ep);
      chk("instr", instr, ei);
      chk("op", 32'(op), ei >> 26);
      chk("rs", 32'(rs), (ei >> 21) & 31);
      chk("rt", 32'(rt), (ei >> 16) & 31);
      chk("rd", 32'(rd), (ei >> 11) & 31);
      chk("shamt", 32'(shamt), (ei >> 6) & 31);
      chk("func", 32'(func), ei & 63);
      chk("index", 32'(instr_index),
          ei & 32'h03FF_FFFF);
      chk("imm", 32'(imm), im);
      chk("sext", imm_sext,
          (im >= 32'h8000) ? (im | 32'hFFFF_0000)
                           : im);
      chk("zext", imm_zext, im);
      chk("lui", imm_lui, im << 16);
      chk("jt", j_target,
          ((ep + 32'd4) & 32'hF000_0000)
          | ((ei & 32'h03FF_FFFF) << 2));
      if (flush) begin
        q.delete();
      end else begin
        po = out_ready && (n > 0);
        pu = in_valid && (n < DEPTH);
        if (po) void'(q.pop_front());
        if (pu) q.push_back('{in_pc, in_instr});
      end
    end
  end

  task automatic step(input logic v,
                      input logic [31:0] p,
                      input logic [31:0] ins,
                      input logic ordy,
                      input logic fl);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_pc     = p;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] np;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sext", imm_sext, 32'd0);
    chk("rst_jt", j_target, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // lui then j, with decode stalled
    step(1, 32'h3000, 32'h3C01_ABCD, 0, 0);
    step(1, 32'h3004, 32'h0800_0C10, 0, 0);
    look();
    chk("lui_valid", 32'(out_valid), 32'd1);
    chk("lui_op", 32'(op), 32'h0F);
    chk("lui_rt", 32'(rt), 32'd1);
    chk("lui_imm", 32'(imm), 32'hABCD);
    chk("lui_lui", imm_lui, 32'hABCD_0000);
    chk("lui_zext", imm_zext, 32'h0000_ABCD);
    chk("lui_sext", imm_sext, 32'hFFFF_ABCD);

    // third push refused while full
    step(1, 32'h3008, 32'h1234_5678, 0, 0);
    look();
    chk("full_count", 32'(count), 32'd2);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1, 32'h3008, 32'h1234_5678, 0, 0);
    look();
    chk("full_hold", 32'(count), 32'd2);
    step(0, 32'h0, 32'h0, 1, 0);
    look();
    chk("pop0_pc", pc, 32'h3000);
    step(0, 32'h0, 32'h0, 1, 0);
    look();
    chk("pop1_pc", pc, 32'h3004);
    chk("j_index", 32'(instr_index), 32'h0C10);
    chk("j_target", j_target, 32'h3040);

    // steady push+pop at occupancy one
    step(1, 32'h3008, $urandom(), 1, 0);
    prev = 32'h3008;
    for (int i = 0; i < 10; i++) begin
      np = 32'h300C + 32'(4 * i);
      step(1, np, $urandom(), 1, 0);
      look();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", pc, prev);
      prev = np;
    end
    step(0, 32'h0, 32'h0, 0, 0);

    // flush with a same-cycle offer
    step(1, 32'h5000, $urandom(), 0, 0);
    step(1, 32'h6000, $urandom(), 0, 1);
    look();
    chk("pre_flush", 32'(count), 32'd2);
    step(0, 32'h0, 32'h0, 0, 0);
    look();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_pc", pc, 32'd0);
    chk("flush_instr", instr, 32'd0);
    step(1, 32'h7000, $urandom(), 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    look();
    chk("post_flush_pc", pc, 32'h7000);

    // asynchronous reset while full
    step(1, 32'h7004, $urandom(), 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    look();
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_pc", pc, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // random traffic, wrap and pc+4 overflow
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 7) == 0)
         ? 32'hFFFF_FFFC
         : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 3) != 0, rp,
           $urandom(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);
    end
    step(0, 32'h0, 32'h0, 1, 0);
    repeat (4) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
